// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM state codes and datapath select codes.
// Opcode constants are 6 bits wide; users zero-extend them to their opcode width.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ST_IF   = 3'd0;
    localparam logic [2:0] ST_ID   = 3'd1;
    localparam logic [2:0] ST_EXE  = 3'd2;
    localparam logic [2:0] ST_WB   = 3'd3;
    localparam logic [2:0] ST_MEM  = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef struct packed {
        logic       ext_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] reg_dst;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode decoder: purely combinational opCode/zero/sign -> datapath selects, zero latency, no flow control.
// Undefined opcodes fall through to the R-type defaults (ALU add, rd destination, sequential PC).
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op_code,
    input  logic            zero,
    input  logic            sign,
    output dec_t            dec
);

    always_comb begin
        dec = '{ext_sel: 1'b1, alu_src_a: 1'b0, alu_src_b: 1'b0,
                reg_dst: RD_RD, alu_op: ALU_ADD, pc_src: PC_INC};
        case (op_code)
            OP_W'(OP_SUB):  dec.alu_op = ALU_SUB;
            OP_W'(OP_ADDI): begin
                dec.alu_src_b = 1'b1;
                dec.reg_dst   = RD_RT;
            end
            OP_W'(OP_OR):   dec.alu_op = ALU_OR;
            OP_W'(OP_AND):  dec.alu_op = ALU_AND;
            OP_W'(OP_ORI):  begin
                dec.ext_sel   = 1'b0;
                dec.alu_src_b = 1'b1;
                dec.reg_dst   = RD_RT;
                dec.alu_op    = ALU_OR;
            end
            OP_W'(OP_SLL):  begin
                dec.alu_src_a = 1'b1;
                dec.alu_op    = ALU_SLL;
            end
            OP_W'(OP_SLT):  dec.alu_op = ALU_SLT;
            OP_W'(OP_SLTIU): begin
                dec.ext_sel   = 1'b0;
                dec.alu_src_b = 1'b1;
                dec.reg_dst   = RD_RT;
                dec.alu_op    = ALU_SLTU;
            end
            OP_W'(OP_SW):   dec.alu_src_b = 1'b1;
            OP_W'(OP_LW):   begin
                dec.alu_src_b = 1'b1;
                dec.reg_dst   = RD_RT;
            end
            // Branch target is only selected when the ALU flag confirms the condition.
            OP_W'(OP_BEQ):  begin
                dec.alu_op = ALU_SUB;
                if (zero) dec.pc_src = PC_BR;
            end
            OP_W'(OP_BLTZ): begin
                dec.alu_op = ALU_SUB;
                if (sign) dec.pc_src = PC_BR;
            end
            OP_W'(OP_J):    dec.pc_src = PC_JMP;
            OP_W'(OP_JR):   dec.pc_src = PC_JR;
            OP_W'(OP_JAL):  begin
                dec.pc_src  = PC_JMP;
                dec.reg_dst = RD_RA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB + HALT/ERR); state registered, controls combinational from state/inputs.
// stall freezes state and counters and masks write enables; not-ready memories hold IF/MEM under a watchdog that leads to ERR.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int MEM_WAIT_EN = 1,
    parameter int TIMEOUT_W   = 4,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [OP_W-1:0]  opCode,
    input  logic             zero,
    input  logic             sign,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             stall,
    input  logic             resume,
    output logic [2:0]       state,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic             mRD,
    output logic             mWR,
    output logic             InsMemRW,
    output logic             ExtSel,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             DBDataSrc,
    output logic             WrRegDSrc,
    output logic [1:0]       RegDst,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam bit WAIT_ON = (MEM_WAIT_EN != 0);
    // The counter value seen in the last tolerated not-ready cycle; one more miss is a timeout.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    logic [2:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    dec_t                 dec;

    logic is_lw, is_sw, is_br, is_j, is_jr, is_jal, is_halt;
    logic fetch_done, mem_done, wait_hit, in_instr, retire, wb_write, waiting;

    mc_ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op_code (opCode),
        .zero    (zero),
        .sign    (sign),
        .dec     (dec)
    );

    assign is_lw   = (opCode == OP_W'(OP_LW));
    assign is_sw   = (opCode == OP_W'(OP_SW));
    assign is_br   = (opCode == OP_W'(OP_BEQ)) || (opCode == OP_W'(OP_BLTZ));
    assign is_j    = (opCode == OP_W'(OP_J));
    assign is_jr   = (opCode == OP_W'(OP_JR));
    assign is_jal  = (opCode == OP_W'(OP_JAL));
    assign is_halt = (opCode == OP_W'(OP_HALT));

    assign wb_write   = !(is_br || is_j || is_jr || is_jal || is_sw || is_halt);
    assign fetch_done = !WAIT_ON || imem_ready;
    assign mem_done   = !WAIT_ON || dmem_ready;
    assign wait_hit   = WAIT_ON && (wait_q == WAIT_LAST);
    assign in_instr   = (state_q == ST_ID) || (state_q == ST_EXE) ||
                        (state_q == ST_MEM) || (state_q == ST_WB);

    always_comb begin
        state_d = state_q;
        if (state_q == ST_HALT) begin
            if (resume && !stall) state_d = ST_IF;
        end else if (!stall) begin
            case (state_q)
                ST_IF: begin
                    if (fetch_done)    state_d = ST_ID;
                    else if (wait_hit) state_d = ST_ERR;
                end
                ST_ID: begin
                    if (is_j || is_jr || is_jal) state_d = ST_IF;
                    else if (is_halt)            state_d = ST_HALT;
                    else                         state_d = ST_EXE;
                end
                ST_EXE: begin
                    if (is_br)               state_d = ST_IF;
                    else if (is_lw || is_sw) state_d = ST_MEM;
                    else                     state_d = ST_WB;
                end
                ST_MEM: begin
                    if (mem_done)      state_d = is_sw ? ST_IF : ST_WB;
                    else if (wait_hit) state_d = ST_ERR;
                end
                ST_WB:   state_d = ST_IF;
                default: state_d = state_q;
            endcase
        end
    end

    assign waiting = !stall && WAIT_ON &&
                     (((state_q == ST_IF) && !imem_ready) || ((state_q == ST_MEM) && !dmem_ready));
    assign retire  = in_instr && (state_d == ST_IF);

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) wait_d = '0;
        else if (waiting)       wait_d = wait_q + TIMEOUT_W'(1);
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IF;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Write enables are qualified by RST so they drop the moment reset asserts, not at the next edge.
    assign PCWre  = RST && retire;
    assign IRWre  = RST && !stall && (state_q == ST_IF) && fetch_done;
    assign RegWre = RST && !stall &&
                    (((state_q == ST_WB) && wb_write) || ((state_q == ST_ID) && is_jal));
    assign mRD    = RST && (state_q == ST_MEM) && is_lw;
    assign mWR    = RST && !stall && (state_q == ST_MEM) && is_sw;

    assign InsMemRW  = 1'b1;
    assign DBDataSrc = is_lw && ((state_q == ST_MEM) || (state_q == ST_WB));
    assign WrRegDSrc = (state_q == ST_WB);

    assign ExtSel  = dec.ext_sel;
    assign ALUSrcA = dec.alu_src_a;
    assign ALUSrcB = dec.alu_src_b;
    assign RegDst  = dec.reg_dst;
    assign ALUOp   = dec.alu_op;
    assign PCSrc   = dec.pc_src;

    assign state   = state_q;
    assign halted  = (state_q == ST_HALT);
    assign err     = (state_q == ST_ERR);
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios plus random opcode/handshake traffic against an instruction-level reference model.
module tb_mc_ctrl_fsm;

    localparam int TW   = 3;
    localparam int MAXW = (1 << TW) - 1;

    localparam int S_IF = 0, S_ID = 1, S_EXE = 2, S_WB = 3, S_MEM = 4, S_HALT = 5, S_ERR = 6;
    localparam int K_ALU = 0, K_BR = 1, K_LW = 2, K_SW = 3, K_J = 4, K_JAL = 5, K_HALT = 6;

    localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_ADDI = 6'b000010,
                           O_OR = 6'b010000, O_AND = 6'b010001, O_ORI = 6'b010010,
                           O_SLL = 6'b011000, O_SLT = 6'b100110, O_SLTIU = 6'b100111,
                           O_SW = 6'b110000, O_LW = 6'b110001, O_BEQ = 6'b110100,
                           O_BLTZ = 6'b110110, O_J = 6'b111000, O_JR = 6'b111001,
                           O_JAL = 6'b111010, O_HALT = 6'b111111, O_UNDEF = 6'b000011;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic [5:0] opCode = O_ADD;
    logic zero = 1'b0, sign = 1'b0, imem_ready = 1'b1, dmem_ready = 1'b1, stall = 1'b0, resume = 1'b0;

    logic [2:0]  state, ALUOp, state_0, ALUOp_0;
    logic        PCWre, IRWre, RegWre, mRD, mWR, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, halted, err;
    logic        PCWre_0, IRWre_0, RegWre_0, mRD_0, mWR_0, InsMemRW_0, ExtSel_0, ALUSrcA_0, ALUSrcB_0;
    logic        DBDataSrc_0, WrRegDSrc_0, halted_0, err_0;
    logic [1:0]  RegDst, PCSrc, RegDst_0, PCSrc_0;
    logic [31:0] retired, retired_0;

    int n_chk = 0;
    int n_err = 0;
    int m_st = S_IF;
    int m_wait = 0;
    logic [31:0] m_ret = '0;

    mc_ctrl_fsm #(.OP_W(6), .MEM_WAIT_EN(1), .TIMEOUT_W(TW), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .opCode(opCode), .zero(zero), .sign(sign),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall(stall), .resume(resume),
        .state(state), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .InsMemRW(InsMemRW), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .PCSrc(PCSrc),
        .ALUOp(ALUOp), .halted(halted), .err(err), .retired(retired)
    );

    mc_ctrl_fsm #(.OP_W(6), .MEM_WAIT_EN(0), .TIMEOUT_W(4), .CNT_W(32)) dut0 (
        .CLK(CLK), .RST(RST), .opCode(opCode), .zero(zero), .sign(sign),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall(stall), .resume(resume),
        .state(state_0), .PCWre(PCWre_0), .IRWre(IRWre_0), .RegWre(RegWre_0), .mRD(mRD_0), .mWR(mWR_0),
        .InsMemRW(InsMemRW_0), .ExtSel(ExtSel_0), .ALUSrcA(ALUSrcA_0), .ALUSrcB(ALUSrcB_0),
        .DBDataSrc(DBDataSrc_0), .WrRegDSrc(WrRegDSrc_0), .RegDst(RegDst_0), .PCSrc(PCSrc_0),
        .ALUOp(ALUOp_0), .halted(halted_0), .err(err_0), .retired(retired_0)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int kind(input logic [5:0] op);
        if (op inside {O_BEQ, O_BLTZ}) return K_BR;
        if (op == O_LW)                return K_LW;
        if (op == O_SW)                return K_SW;
        if (op inside {O_J, O_JR})     return K_J;
        if (op == O_JAL)               return K_JAL;
        if (op == O_HALT)              return K_HALT;
        return K_ALU;
    endfunction

    // {ExtSel, ALUSrcA, ALUSrcB, RegDst, ALUOp, PCSrc} from the decode rules
    function automatic logic [9:0] exp_dec(input logic [5:0] op, input logic z, input logic s);
        logic       ext, sa, sb;
        logic [1:0] rd, pc;
        logic [2:0] alu;
        ext = !(op inside {O_ORI, O_SLTIU});
        sa  = (op == O_SLL);
        sb  = op inside {O_ADDI, O_ORI, O_SLTIU, O_LW, O_SW};
        rd  = (op == O_JAL) ? 2'b00 : (op inside {O_ADDI, O_ORI, O_SLTIU, O_LW}) ? 2'b01 : 2'b10;
        if (op inside {O_SUB, O_BEQ, O_BLTZ}) alu = 3'd1;
        else if (op == O_SLTIU)               alu = 3'd2;
        else if (op == O_SLT)                 alu = 3'd3;
        else if (op == O_SLL)                 alu = 3'd4;
        else if (op inside {O_OR, O_ORI})     alu = 3'd5;
        else if (op == O_AND)                 alu = 3'd6;
        else                                  alu = 3'd0;
        if ((op == O_BEQ && z) || (op == O_BLTZ && s)) pc = 2'b01;
        else if (op == O_JR)                           pc = 2'b10;
        else if (op inside {O_J, O_JAL})               pc = 2'b11;
        else                                           pc = 2'b00;
        return {ext, sa, sb, rd, alu, pc};
    endfunction

    // Entered and left just after a falling edge: drive, check against the model, clock, advance the model.
    task automatic cycle(input logic [5:0] op, input logic im, input logic dm, input logic st,
                         input logic rs, input logic z, input logic sg);
        int nxt, k;
        bit stl, ret, to;
        opCode = op; imem_ready = im; dmem_ready = dm; stall = st; resume = rs; zero = z; sign = sg;
        #1;
        k   = kind(op);
        stl = st && (m_st != S_HALT) && (m_st != S_ERR);
        to  = (m_wait + 1 == MAXW);
        nxt = m_st;
        if (m_st == S_HALT) begin
            if (rs && !st) nxt = S_IF;
        end else if (!stl) begin
            case (m_st)
                S_IF:  if (im) nxt = S_ID; else if (to) nxt = S_ERR;
                S_ID:  nxt = (k == K_J || k == K_JAL) ? S_IF : (k == K_HALT) ? S_HALT : S_EXE;
                S_EXE: nxt = (k == K_BR) ? S_IF : (k == K_LW || k == K_SW) ? S_MEM : S_WB;
                S_MEM: if (dm) nxt = (k == K_SW) ? S_IF : S_WB; else if (to) nxt = S_ERR;
                S_WB:  nxt = S_IF;
                default: ;
            endcase
        end
        ret = (m_st >= S_ID) && (m_st <= S_MEM) && (nxt == S_IF);
        chk("state", 32'(state), 32'(m_st));
        chk("PCWre", 32'(PCWre), 32'(ret));
        chk("IRWre", 32'(IRWre), 32'(m_st == S_IF && !stl && im));
        chk("RegWre", 32'(RegWre), 32'(!stl && ((m_st == S_WB && (k == K_ALU || k == K_LW)) ||
                                               (m_st == S_ID && k == K_JAL))));
        chk("mRD", 32'(mRD), 32'(m_st == S_MEM && k == K_LW));
        chk("mWR", 32'(mWR), 32'(m_st == S_MEM && k == K_SW && !stl));
        chk("DBDataSrc", 32'(DBDataSrc), 32'((m_st == S_MEM || m_st == S_WB) && k == K_LW));
        if (m_st == S_WB) chk("WrRegDSrc_wb", 32'(WrRegDSrc), 32'd1);
        if (m_st == S_ID) chk("WrRegDSrc_id", 32'(WrRegDSrc), 32'd0);
        chk("halted", 32'(halted), 32'(m_st == S_HALT));
        chk("err", 32'(err), 32'(m_st == S_ERR));
        chk("retired", retired, m_ret);
        chk("InsMemRW", 32'(InsMemRW), 32'd1);
        chk("decode", 32'({ExtSel, ALUSrcA, ALUSrcB, RegDst, ALUOp, PCSrc}), 32'(exp_dec(op, z, sg)));
        @(posedge CLK);
        if (nxt != m_st) m_wait = 0;
        else if (!stl && ((m_st == S_IF && !im) || (m_st == S_MEM && !dm))) m_wait++;
        m_ret = m_ret + 32'(ret);
        m_st  = nxt;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0; imem_ready = 1'b1; stall = 1'b0; resume = 1'b0; opCode = O_ADD;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enables", 32'({PCWre, IRWre, RegWre, mRD, mWR}), 32'd0);
        chk("rst_flags", 32'({halted, err}), 32'd0);
        chk("rst_retired", retired, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        m_st = S_IF; m_wait = 0; m_ret = '0;
    endtask

    logic [5:0] ops [17];
    logic [5:0] cur_op;
    logic [31:0] r0;
    bit slow;
    int exp_st0 [4] = '{1, 2, 3, 0};

    initial begin
        ops = '{O_ADD, O_SUB, O_ADDI, O_OR, O_AND, O_ORI, O_SLL, O_SLT, O_SLTIU,
                O_SW, O_LW, O_BEQ, O_BLTZ, O_J, O_JR, O_JAL, O_HALT};
        @(negedge CLK);
        do_reset();

        // ADD on the single-cycle-memory variant; ready inputs held low must be ignored
        for (int i = 0; i < 4; i++) begin
            opCode = O_ADD; imem_ready = 1'b0; dmem_ready = 1'b0;
            #1;
            chk("add0_pcwre", 32'(PCWre_0), 32'(i == 3));
            chk("add0_regwre", 32'(RegWre_0), 32'(i == 3));
            chk("add0_irwre", 32'(IRWre_0), 32'(i == 0));
            chk("add0_mem", 32'({mRD_0, mWR_0, DBDataSrc_0, halted_0, err_0}), 32'd0);
            chk("add0_misc", 32'({InsMemRW_0, WrRegDSrc_0}), 32'({1'b1, i == 3}));
            chk("add0_dec", 32'({ExtSel_0, ALUSrcA_0, ALUSrcB_0, RegDst_0, ALUOp_0, PCSrc_0}),
                32'(exp_dec(O_ADD, 1'b0, 1'b0)));
            cycle(O_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("add0_state", 32'(state_0), 32'(exp_st0[i]));
        end
        chk("add0_retired", retired_0, 32'd1);

        // LW with a slow data memory
        do_reset();
        repeat (3) cycle(O_LW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_in_mem", 32'(state), 32'(S_MEM));
        r0 = retired;
        repeat (3) cycle(O_LW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_mem_hold", 32'(state), 32'(S_MEM));
        chk("lw_mrd", 32'({mRD, DBDataSrc}), 32'b11);
        cycle(O_LW, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_wb", 32'(state), 32'(S_WB));
        chk("lw_wb_ctl", 32'({RegWre, RegDst}), 32'b101);
        cycle(O_LW, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_retired", retired, r0 + 32'd1);

        // Taken BEQ is a three-cycle instruction; BLTZ with sign=0 falls through
        r0 = retired;
        repeat (2) cycle(O_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("beq_pcsrc", 32'({PCSrc, PCWre}), 32'b011);
        cycle(O_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("beq_done", 32'(state), 32'(S_IF));
        chk("beq_retired", retired, r0 + 32'd1);
        repeat (2) cycle(O_BLTZ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bltz_pcsrc", 32'(PCSrc), 32'd0);
        cycle(O_BLTZ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // JAL writes the link register from ID and retires there
        cycle(O_JAL, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jal_id", 32'({RegWre, RegDst, PCSrc, WrRegDSrc, PCWre}), 32'b1_00_11_0_1);
        cycle(O_JAL, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jal_done", 32'(state), 32'(S_IF));

        // HALT parks until a resume that is not masked by stall
        repeat (2) cycle(O_HALT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        r0 = retired;
        repeat (10) cycle(O_HALT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_state", 32'({29'd0, state} | (32'(halted) << 8)), 32'h105);
        chk("halt_retired", retired, r0);
        cycle(O_HALT, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("halt_stall_resume", 32'(state), 32'(S_HALT));
        cycle(O_HALT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("halt_resume", 32'(state), 32'(S_IF));

        // SW stalled in MEM, then reset asserted mid-MEM
        repeat (3) cycle(O_SW, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(O_SW, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sw_stall_hold", 32'(state), 32'(S_MEM));
        opCode = O_SW; dmem_ready = 1'b0; stall = 1'b1;
        #1;
        chk("sw_stall_mwr", 32'(mWR), 32'd0);
        stall = 1'b0;
        #1;
        chk("sw_mwr", 32'(mWR), 32'd1);
        RST = 1'b0;
        #1;
        chk("rst_mid_mem", 32'({state, mWR, mRD}), 32'd0);
        do_reset();

        // Instruction memory never ready: ERR after 2^TW-1 misses, then absorbing
        for (int i = 0; i < MAXW; i++) begin
            cycle(O_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == MAXW - 2) chk("to_before", 32'(state), 32'(S_IF));
        end
        chk("to_err", 32'({state, err}), 32'({3'(S_ERR), 1'b1}));
        repeat (3) cycle(O_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("to_sticky", 32'({state, err}), 32'({3'(S_ERR), 1'b1}));
        do_reset();

        // Random traffic; slow phases make timeouts reachable
        cur_op = O_ADD;
        slow = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) slow = ($urandom_range(0, 2) == 0);
            if (m_st == S_ERR) begin
                cycle(cur_op, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                do_reset();
                continue;
            end
            if (m_st == S_IF)
                cur_op = ($urandom_range(0, 19) == 0) ? O_UNDEF : ops[$urandom_range(0, 16)];
            cycle(cur_op,
                  slow ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0),
                  slow ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) < 3),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
